// File: rtl/fifo_write_ctrl.sv
// Write-side pointer/flag controller for an asynchronous FIFO: write pointer, read-pointer
// synchroniser, full / almost-full / level flags. Optional macro FIFO_WR_OVERFLOW_EN adds a sticky overflow flag.

module gray_to_binary #(
  parameter int unsigned W = 5
) (
  input  logic [W-1:0] i_gray,
  output logic [W-1:0] o_bin
);

  // Each binary bit is the XOR of all Gray bits at or above it
  always_comb begin
    o_bin = '0;
    for (int i = 0; i < int'(W); i++) begin
      o_bin[i] = ^(i_gray >> i);
    end
  end

endmodule

module fifo_write_ctrl #(
  parameter int unsigned SIZE      = 4,
  parameter int unsigned AF_THRESH = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [SIZE:0]   rd_gray_async,
  output logic            mem_we,
  output logic [SIZE-1:0] wr_addr,
  output logic [SIZE:0]   wr_gray,
  output logic            full,
  output logic            almost_full,
  output logic [SIZE:0]   wr_level
`ifdef FIFO_WR_OVERFLOW_EN
  ,
  output logic            overflow
`endif
);

  localparam int unsigned PW = SIZE + 1;

  logic [PW-1:0] r_wbin;
  logic [PW-1:0] r_rq1;
  logic [PW-1:0] r_rq2;
  logic [PW-1:0] w_wbin_next;
  logic [PW-1:0] w_wgray_next;
  logic [PW-1:0] w_rbin_s;
  logic [PW-1:0] w_full_cmp;
  logic [PW-1:0] w_level_next;
  logic          w_full_next;
  logic          w_af_next;

  assign mem_we       = wr_en & ~full;
  assign w_wbin_next  = r_wbin + PW'(mem_we);
  assign w_wgray_next = w_wbin_next ^ (w_wbin_next >> 1);
  assign wr_addr      = r_wbin[SIZE-1:0];

  gray_to_binary #(.W(PW)) u_rd_g2b (
    .i_gray (r_rq2),
    .o_bin  (w_rbin_s)
  );

  // Full when the write pointer is exactly one lap ahead of the synchronised read pointer
  assign w_full_cmp   = {~r_rq2[SIZE:SIZE-1], r_rq2[SIZE-2:0]};
  assign w_full_next  = (w_wgray_next == w_full_cmp);
  assign w_level_next = w_wbin_next - w_rbin_s;
  assign w_af_next    = (32'(w_level_next) >= AF_THRESH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wbin      <= '0;
      wr_gray     <= '0;
      r_rq1       <= '0;
      r_rq2       <= '0;
      wr_level    <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      r_wbin      <= w_wbin_next;
      wr_gray     <= w_wgray_next;
      r_rq1       <= rd_gray_async;
      r_rq2       <= r_rq1;
      wr_level    <= w_level_next;
      full        <= w_full_next;
      almost_full <= w_af_next;
    end
  end

`ifdef FIFO_WR_OVERFLOW_EN
  // Sticky record of any write attempted while full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (wr_en & full) begin
      overflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_write_ctrl.sv
// Self-checking bench for fifo_write_ctrl: occupancy model on integer write/read counts,
// directed scenarios with literal expectations, then randomized traffic.

module tb_fifo_write_ctrl;

  localparam int SIZE  = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 12;

  logic            clk;
  logic            rst_n;
  logic            wr_en;
  logic [SIZE:0]   rd_gray_async;
  logic            mem_we;
  logic [SIZE-1:0] wr_addr;
  logic [SIZE:0]   wr_gray;
  logic            full;
  logic            almost_full;
  logic [SIZE:0]   wr_level;
`ifdef FIFO_WR_OVERFLOW_EN
  logic            overflow;
`endif

  fifo_write_ctrl #(.SIZE(SIZE), .AF_THRESH(AF)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_en         (wr_en),
    .rd_gray_async (rd_gray_async),
    .mem_we        (mem_we),
    .wr_addr       (wr_addr),
    .wr_gray       (wr_gray),
    .full          (full),
    .almost_full   (almost_full),
    .wr_level      (wr_level)
`ifdef FIFO_WR_OVERFLOW_EN
    ,
    .overflow      (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;
  int rd_cnt   = 0;

  // Model: total accepted writes, read count seen after two write-clock edges, occupancy
  int m_w, m_lvl, m_rq1, m_rq2, m_acc;
  bit m_ovf;

  function automatic logic [SIZE:0] gray5(input int v);
    logic [SIZE:0] b;
    b = (SIZE+1)'(v);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  assign m_acc = (wr_en && (m_lvl != DEPTH)) ? 1 : 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_w   <= 0;
      m_lvl <= 0;
      m_rq1 <= 0;
      m_rq2 <= 0;
      m_ovf <= 1'b0;
    end else begin
      m_w   <= m_w + m_acc;
      m_lvl <= m_w + m_acc - m_rq2;
      m_rq1 <= rd_cnt;
      m_rq2 <= m_rq1;
      if (wr_en && (m_lvl == DEPTH)) m_ovf <= 1'b1;
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      chk("mem_we", int'(mem_we), m_acc);
      chk("wr_addr", int'(wr_addr), m_w % DEPTH);
      chk("wr_gray", int'(wr_gray), int'(gray5(m_w)));
      chk("wr_level", int'(wr_level), m_lvl);
      chk("full", int'(full), (m_lvl == DEPTH) ? 1 : 0);
      chk("almost_full", int'(almost_full), (m_lvl >= AF) ? 1 : 0);
`ifdef FIFO_WR_OVERFLOW_EN
      chk("overflow", int'(overflow), int'(m_ovf));
`endif
    end
  end

  // Drive inputs now, return just after the following edge's outputs have settled
  task automatic cyc(input bit we, input int rd);
    wr_en         = we;
    rd_cnt        = rd;
    rd_gray_async = gray5(rd);
    @(posedge clk);
    @(negedge clk);
    #3;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    wr_en         = 1'b0;
    rd_cnt        = 0;
    rd_gray_async = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #3;
  endtask

  initial begin
    int wc;
    int rd;
    rst_n         = 1'b0;
    wr_en         = 1'b0;
    rd_gray_async = '0;
    #1;
    chk("rst_level", int'(wr_level), 0);
    chk("rst_gray", int'(wr_gray), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_af", int'(almost_full), 0);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    #3;

    // Fill to full
    for (int k = 1; k <= DEPTH; k++) begin
      cyc(1'b1, 0);
      chk("fill_addr", int'(wr_addr), k % DEPTH);
      chk("fill_af", int'(almost_full), (k >= AF) ? 1 : 0);
      chk("fill_full", int'(full), (k == DEPTH) ? 1 : 0);
    end
    chk("fill_level", int'(wr_level), 16);

    // Overflow attempts
    for (int k = 0; k < 3; k++) begin
      wr_en = 1'b1;
      #1;
      chk("ovf_mem_we", int'(mem_we), 0);
      cyc(1'b1, 0);
      chk("ovf_gray", int'(wr_gray), 24);
      chk("ovf_level", int'(wr_level), 16);
`ifdef FIFO_WR_OVERFLOW_EN
      chk("ovf_flag", int'(overflow), 1);
`endif
    end

    // Read release visible two edges later
    cyc(1'b0, 3);
    chk("rel_full_e", int'(full), 1);
    cyc(1'b0, 3);
    chk("rel_full_e1", int'(full), 1);
    chk("rel_level_e1", int'(wr_level), 16);
    cyc(1'b0, 3);
    chk("rel_full_e2", int'(full), 0);
    chk("rel_level_e2", int'(wr_level), 13);

    // Wrap-around with the read pointer tracking the writes
    wc = 16;
    for (int k = 0; k < 3; k++) cyc(1'b0, wc);
    for (int k = 0; k < 15; k++) begin
      cyc(1'b1, wc);
      wc++;
      chk("wrap_nofull", int'(full), 0);
    end
    chk("wrap_gray31", int'(wr_gray), 16);
    cyc(1'b1, wc);
    chk("wrap_gray0", int'(wr_gray), 0);
    chk("wrap_addr0", int'(wr_addr), 0);

    // Simultaneous write and read advance from level 8
    do_reset();
    for (int k = 0; k < 8; k++) cyc(1'b1, 0);
    chk("sim_level8", int'(wr_level), 8);
    cyc(1'b1, 1);
    chk("sim_level9", int'(wr_level), 9);
    cyc(1'b0, 1);
    chk("sim_level9b", int'(wr_level), 9);
    cyc(1'b0, 1);
    chk("sim_level8b", int'(wr_level), 8);

    // Asynchronous reset mid-burst at level 10
    cyc(1'b1, 1);
    cyc(1'b1, 1);
    chk("burst_level10", int'(wr_level), 10);
    wr_en  = 1'b1;
    rst_n  = 1'b0;
    rd_cnt = 0;
    rd_gray_async = '0;
    #1;
    chk("arst_level", int'(wr_level), 0);
    chk("arst_gray", int'(wr_gray), 0);
    chk("arst_addr", int'(wr_addr), 0);
    chk("arst_full", int'(full), 0);
    chk("arst_mem_we", int'(mem_we), 1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_addr", int'(wr_addr), 0);
    chk("post_rst_we", int'(mem_we), 1);
    #2;
    cyc(1'b1, 0);
    chk("post_rst_addr1", int'(wr_addr), 1);

    // Randomized traffic: slow reads first to reach full, then faster reads
    rd = 0;
    for (int k = 0; k < 1500; k++) begin
      int room;
      int adv;
      room = m_w - rd;
      if (k < 500) adv = ($urandom_range(0, 7) == 0) ? 1 : 0;
      else         adv = $urandom_range(0, 2);
      if (adv > room) adv = room;
      rd = rd + adv;
      cyc(($urandom_range(0, 3) != 0), rd);
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
